code_run_encoder: RTL and testbench

Run-length encoder for the 2-bit state code produced by the nested if/else decode stage, which drives a `[1:0]` code each cycle and returns to 0 on reset. The block sits directly downstream of that stage. It collapses consecutive identical codes into (code, length) pairs and buffers them in a small FIFO. It presents the pairs to the consumer over a valid/ready handshake.

---
 rtl/code_run_encoder_if.sv | 32 +++
 rtl/code_run_encoder.sv | 179 +++++++++++++++++
 tb/tb_code_run_encoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_run_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : code_run_encoder_if
// Description : Code input, flush and (code, length) output handshake bundle
//               of the run-length encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface code_run_encoder_if #(
   parameter int CNT_W = 6
);
   logic [1:0]       code_in;
   logic             code_valid;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_code;
   logic [CNT_W-1:0] out_len;
   logic             overflow;

   // Producer/consumer side: feeds codes and accepts pairs
   modport master (
      output code_in, code_valid, flush, out_ready,
      input  out_valid, out_code, out_len, overflow
   );

   // Encoder side
   modport slave (
      input  code_in, code_valid, flush, out_ready,
      output out_valid, out_code, out_len, overflow
   );
endinterface
`default_nettype wire

// File: rtl/code_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : code_run_encoder
// Description : Collapses consecutive identical 2-bit codes into (code, length)
//               pairs, stages each closed pair for one cycle and buffers it in
//               a FIFO presented over a valid/ready handshake.
//               Optional build macro CODE_RUN_DROP_ZERO_EN: closed runs of
//               code 0 are discarded before reaching the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module code_run_encoder #(
   parameter int CNT_W      = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic         clock,
   input  wire logic         reset,
   code_run_encoder_if.slave bus
);
   localparam int               c_addr_w  = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] c_max_len = '1;
   localparam logic [CNT_W-1:0] c_len_one = CNT_W'(1);
   localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_cur_code;
   logic [1:0]       w_cur_code_nxt;
   logic [CNT_W-1:0] r_cur_len;
   logic [CNT_W-1:0] w_cur_len_nxt;

   logic             w_close;
   logic [1:0]       w_close_code;
   logic [CNT_W-1:0] w_close_len;
   logic             w_keep;

   // One-cycle staging register between run closure and FIFO write
   logic             r_pend_valid;
   logic [1:0]       r_pend_code;
   logic [CNT_W-1:0] r_pend_len;

   logic [CNT_W+1:0] r_mem [FIFO_DEPTH];
   logic [c_addr_w:0] r_wr_ptr;
   logic [c_addr_w:0] r_rd_ptr;
   logic             r_overflow;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_write;
   logic [CNT_W+1:0] w_head;

   // Run tracker register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cur_code <= 2'd0;
         r_cur_len  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_code <= w_cur_code_nxt;
         r_cur_len  <= w_cur_len_nxt;
      end
   end

   // Run tracker next state: extend, saturate-and-restart, or close the run
   always_comb begin
      w_state_nxt    = r_state;
      w_cur_code_nxt = r_cur_code;
      w_cur_len_nxt  = r_cur_len;
      w_close        = 1'b0;
      w_close_code   = r_cur_code;
      w_close_len    = r_cur_len;
      case (r_state)
         S_IDLE: begin
            if (bus.code_valid) begin
               w_state_nxt    = S_RUN;
               w_cur_code_nxt = bus.code_in;
               w_cur_len_nxt  = c_len_one;
            end
         end
         S_RUN: begin
            if (bus.flush) begin
               // A code arriving with the flush belongs to the next run
               w_close = 1'b1;
               if (bus.code_valid) begin
                  w_cur_code_nxt = bus.code_in;
                  w_cur_len_nxt  = c_len_one;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (bus.code_valid) begin
               if (bus.code_in == r_cur_code) begin
                  if (r_cur_len == c_max_len) begin
                     w_close       = 1'b1;
                     w_cur_len_nxt = c_len_one;
                  end else begin
                     w_cur_len_nxt = r_cur_len + c_len_one;
                  end
               end else begin
                  w_close        = 1'b1;
                  w_cur_code_nxt = bus.code_in;
                  w_cur_len_nxt  = c_len_one;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef CODE_RUN_DROP_ZERO_EN
   // Code 0 is the upstream idle/reset code; its runs carry no information
   assign w_keep = w_close && (w_close_code != 2'd0);
`else
   assign w_keep = w_close;
`endif

   // Stage the closed pair for one cycle before it is written into the FIFO
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend_valid <= 1'b0;
         r_pend_code  <= 2'd0;
         r_pend_len   <= '0;
      end else begin
         r_pend_valid <= w_keep;
         r_pend_code  <= w_close_code;
         r_pend_len   <= w_close_len;
      end
   end

   // Extra pointer bit separates full (MSBs differ) from empty (equal)
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                    (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
   assign w_pop   = !w_empty && bus.out_ready;
   // A pop in the same cycle frees the slot the write lands in
   assign w_write = r_pend_valid && (!w_full || w_pop);

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (r_pend_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clock) begin
      if (w_write) begin
         r_mem[r_wr_ptr[c_addr_w-1:0]] <= {r_pend_code, r_pend_len};
      end
   end

   // Head pair is forced to zero while the FIFO is empty
   assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr[c_addr_w-1:0]];
   assign bus.out_valid = !w_empty;
   assign bus.out_code  = w_head[CNT_W+1:CNT_W];
   assign bus.out_len   = w_head[CNT_W-1:0];
   assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_code_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_run_encoder
// Description : Self-checking bench for code_run_encoder: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_run_encoder;
   localparam int CNT_W      = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int MAXLEN     = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [CNT_W+1:0] got_q[$];
   logic [CNT_W+1:0] exp_q[$];

   code_run_encoder_if #(.CNT_W(CNT_W)) bus ();

   code_run_encoder #(
      .CNT_W      (CNT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [CNT_W+1:0] mk(input int c, input int l);
      return {c[1:0], l[CNT_W-1:0]};
   endfunction

   // One cycle of stimulus; records the pair handed over at the coming edge
   task automatic drive(input logic cv, input logic [1:0] c, input logic fl, input logic rdy);
      bus.code_valid = cv;
      bus.code_in    = c;
      bus.flush      = fl;
      bus.out_ready  = rdy;
      if (bus.out_valid === 1'b1 && rdy)
         got_q.push_back({bus.out_code, bus.out_len});
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      got_q.delete();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, rdy);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1);
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.out_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", bus.out_code); end
      n_cmp++; if (bus.out_len !== '0) begin n_fail++; $display("FAIL reset_len: got %0d expected 0", bus.out_len); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
      reset = 1'b0;
      got_q.delete();
   endtask

   task automatic test_basic_runs();
      do_reset();
      drive(1'b1, 2'd2, 1'b0, 1'b1);
      drive(1'b1, 2'd2, 1'b0, 1'b1);
      drive(1'b1, 2'd2, 1'b0, 1'b1);
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      // closed at the last edge: not yet visible, visible one edge later
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency0: got %b expected 0", bus.out_valid); end
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency1: got %b expected 1", bus.out_valid); end
      idle(5, 1'b1);
      exp_q = '{mk(2, 3), mk(1, 1)};
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [CNT_W+1:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL basic_pair%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 9; i++) drive(1'b1, 2'd3, 1'b0, 1'b1);
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      idle(5, 1'b1);
      exp_q = '{mk(3, MAXLEN), mk(3, 2)};
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [CNT_W+1:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL sat_pair%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_gaps();
      do_reset();
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      idle(5, 1'b1);
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      idle(5, 1'b1);
      n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL gaps_count: got %0d expected 1", got_q.size()); end
      n_cmp++; if (got_q.size() < 1 || got_q[0] !== mk(1, 2)) begin n_fail++; $display("FAIL gaps_pair: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 'x, mk(1, 2)); end
   endtask

   task automatic test_overflow();
      logic [1:0] seq [11] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
      do_reset();
      foreach (seq[i]) drive(1'b1, seq[i], 1'b0, 1'b0);
      idle(3, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", bus.out_valid); end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
      idle(8, 1'b1);
      exp_q = '{mk(1, 1), mk(2, 2), mk(3, 3), mk(1, 1)};
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [CNT_W+1:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL ovf_pair%0d: got %h expected %h", i, g, exp_q[i]); end
      end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
      do_reset();
      foreach (seq[i]) drive(1'b1, seq[i], 1'b0, 1'b0);
      idle(2, 1'b0);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b expected 0", bus.overflow); end
      idle(7, 1'b1);
      exp_q = '{mk(1, 1), mk(2, 1), mk(3, 1), mk(1, 1), mk(2, 1)};
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fullpop_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [CNT_W+1:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL fullpop_pair%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      drive(1'b1, 2'd1, 1'b0, 1'b0);
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      idle(2, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", bus.out_valid); end
      reset = 1'b1;
      drive(1'b1, 2'd2, 1'b1, 1'b0);
      reset = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b expected 0", bus.overflow); end
      got_q.delete();
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      idle(5, 1'b1);
      n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d pairs expected 0", got_q.size()); end
      drive(1'b1, 2'd3, 1'b0, 1'b1);
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      idle(4, 1'b1);
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== mk(3, 1)) begin n_fail++; $display("FAIL midrst_fresh: got %0d pairs first %h expected 1 pair %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, mk(3, 1)); end
   endtask

   task automatic test_drop_zero();
      do_reset();
      drive(1'b1, 2'd0, 1'b0, 1'b1);
      drive(1'b1, 2'd0, 1'b0, 1'b1);
      drive(1'b1, 2'd2, 1'b0, 1'b1);
      drive(1'b1, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 2'd0, 1'b1, 1'b1);
      idle(5, 1'b1);
`ifdef CODE_RUN_DROP_ZERO_EN
      exp_q = '{mk(2, 1)};
`else
      exp_q = '{mk(0, 2), mk(2, 1), mk(0, 1)};
`endif
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [CNT_W+1:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL zero_pair%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   // Randomized traffic; the model tracks the open run as (code, length) and
   // the buffer as a queue fed one cycle after a run closes
   task automatic test_random(input int cycles, input int ready_pct);
      bit               m_open, m_pv, m_ovf, closed, keep, pop, full;
      logic [1:0]       m_code, cc, c, last;
      int               m_len, cl;
      logic [CNT_W+1:0] m_pend;
      logic [CNT_W+1:0] m_q[$];
      logic             cv, fl, rdy;
      do_reset();
      m_open = 0; m_pv = 0; m_ovf = 0; m_code = 0; m_len = 0; m_pend = '0; last = 2'd0;
      for (int n = 0; n < cycles; n++) begin
         cv  = ($urandom_range(0, 9) < 8);
         c   = ($urandom_range(0, 9) < 7) ? last : 2'($urandom_range(0, 3));
         last = c;
         fl  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 99) < ready_pct);
         full = (m_q.size() == FIFO_DEPTH);
         pop  = (m_q.size() > 0) && rdy;
         if (pop) void'(m_q.pop_front());
         if (m_pv) begin
            if (full && !pop) m_ovf = 1;
            else m_q.push_back(m_pend);
         end
         closed = 0; cc = m_code; cl = m_len;
         if (!m_open) begin
            if (cv) begin m_open = 1; m_code = c; m_len = 1; end
         end else if (fl) begin
            closed = 1;
            if (cv) begin m_code = c; m_len = 1; end
            else m_open = 0;
         end else if (cv) begin
            if (c == m_code && m_len < MAXLEN) m_len++;
            else begin closed = 1; m_code = c; m_len = 1; end
         end
`ifdef CODE_RUN_DROP_ZERO_EN
         keep = closed && (cc != 2'd0);
`else
         keep = closed;
`endif
         m_pv = keep;
         m_pend = mk(cc, cl);
         drive(cv, c, fl, rdy);
         n_cmp++; if (bus.out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", n, bus.out_valid, m_q.size() > 0); end
         if (m_q.size() > 0) begin
            n_cmp++; if ({bus.out_code, bus.out_len} !== m_q[0]) begin n_fail++; $display("FAIL rand_head@%0d: got %h expected %h", n, {bus.out_code, bus.out_len}, m_q[0]); end
         end
         n_cmp++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow@%0d: got %b expected %b", n, bus.overflow, m_ovf); end
      end
   endtask

   initial begin
      bus.code_valid = 1'b0;
      bus.code_in    = 2'd0;
      bus.flush      = 1'b0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_basic_runs();
      test_saturation();
      test_gaps();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_run();
      test_drop_zero();
      test_random(500, 75);
      test_random(500, 35);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
